// File: rtl/mdu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_ctrl_pkg
// Description : Shared definitions for the multiply/divide unit controller.
//               Holds the MDU op encodings, the default latencies, the
//               controller state encodings and small op-decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_ctrl_pkg;

    // MDU op encodings carried on E_mdOp.
    localparam logic [2:0] c_opMult  = 3'd0;
    localparam logic [2:0] c_opMultu = 3'd1;
    localparam logic [2:0] c_opDiv   = 3'd2;
    localparam logic [2:0] c_opDivu  = 3'd3;
    localparam logic [2:0] c_opMthi  = 3'd4;
    localparam logic [2:0] c_opMtlo  = 3'd5;

    // Default busy latencies in cycles.
    localparam int c_multLatDefault = 5;
    localparam int c_divLatDefault  = 10;

    // Controller state encodings.
    localparam logic [0:0] c_stIdle = 1'b0;
    localparam logic [0:0] c_stBusy = 1'b1;

    // Ops that occupy the unit for several cycles.
    function automatic logic isMulDiv(input logic [2:0] op);
        return (op == c_opMult) || (op == c_opMultu) ||
               (op == c_opDiv)  || (op == c_opDivu);
    endfunction

    function automatic logic isMulOp(input logic [2:0] op);
        return (op == c_opMult) || (op == c_opMultu);
    endfunction

    function automatic logic isSignedOp(input logic [2:0] op);
        return (op == c_opMult) || (op == c_opDiv);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_arith.sv
`default_nettype none
// ============================================================================
// Module      : mdu_arith
// Description : Combinational MDU datapath. Produces the 64-bit product and
//               the 32-bit quotient/remainder of the latched operands for
//               signed or unsigned ops.
// Ports       : i_a, i_b    latched operands (rs, rt)
//               i_op        latched MDU op
//               o_prod      64-bit product {hi, lo}
//               o_quot      quotient (goes to lo)
//               o_rem       remainder (goes to hi)
//               o_divZero   divisor is zero; results must not be written
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [2:0]  i_op,
    output logic [63:0] o_prod,
    output logic [31:0] o_quot,
    output logic [31:0] o_rem,
    output logic        o_divZero
);

    logic        w_signed;
    logic [63:0] w_aExt;
    logic [63:0] w_bExt;
    logic        w_aNeg;
    logic        w_bNeg;
    logic [31:0] w_aMag;
    logic [31:0] w_bMag;
    logic [31:0] w_divisor;
    logic [31:0] w_qMag;
    logic [31:0] w_rMag;

    assign w_signed  = isSignedOp(i_op);
    assign o_divZero = (i_b == 32'd0);

    // Sign- or zero-extend to 64 bits; the low 64 bits of the 64x64 product
    // are then the correct result in either interpretation.
    assign w_aExt = w_signed ? {{32{i_a[31]}}, i_a} : {32'd0, i_a};
    assign w_bExt = w_signed ? {{32{i_b[31]}}, i_b} : {32'd0, i_b};
    assign o_prod = w_aExt * w_bExt;

    // Division works on magnitudes and fixes signs afterwards. This also
    // covers 0x80000000 / -1: the magnitude 2^31 fits unsigned, the quotient
    // comes out as 0x80000000 with no negation and the remainder is zero.
    assign w_aNeg = w_signed & i_a[31];
    assign w_bNeg = w_signed & i_b[31];
    assign w_aMag = w_aNeg ? (32'd0 - i_a) : i_a;
    assign w_bMag = w_bNeg ? (32'd0 - i_b) : i_b;

    // Keep the divider well defined on a zero divisor; the result is discarded.
    assign w_divisor = o_divZero ? 32'd1 : w_bMag;
    assign w_qMag    = w_aMag / w_divisor;
    assign w_rMag    = w_aMag % w_divisor;

    // Truncation toward zero; the remainder follows the dividend's sign.
    assign o_quot = (w_aNeg ^ w_bNeg) ? (32'd0 - w_qMag) : w_qMag;
    assign o_rem  = w_aNeg ? (32'd0 - w_rMag) : w_rMag;

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mdu_ctrl
// Description : Multiply/divide unit controller. Sequences a fixed-latency
//               multi-cycle MULT/DIV, owns the HI/LO registers, handles
//               MTHI/MTLO and raises the D-stage stall request.
// Ports       : clk        clock, rising edge
//               reset      synchronous active-high reset
//               E_start    E-stage holds an MDU instruction
//               E_mdOp     MDU op code
//               E_a, E_b   forwarded rs / rt values
//               D_isMd     D-stage instruction uses the MDU
//               busy       multi-cycle operation in progress (registered)
//               hi, lo     architectural HI / LO
//               D_mdStall  stall request to the D stage
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_LAT = c_multLatDefault,
    parameter int DIV_LAT  = c_divLatDefault
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        E_start,
    input  logic [2:0]  E_mdOp,
    input  logic [31:0] E_a,
    input  logic [31:0] E_b,
    input  logic        D_isMd,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        D_mdStall
);

    localparam logic [3:0] c_multCnt = 4'(MULT_LAT);
    localparam logic [3:0] c_divCnt  = 4'(DIV_LAT);

    logic [0:0]  r_state;
    logic [3:0]  r_count;
    logic [31:0] r_opA;
    logic [31:0] r_opB;
    logic [2:0]  r_op;
    logic        r_busy;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic        w_divZero;

    mdu_arith u_arith (
        .i_a       (r_opA),
        .i_b       (r_opB),
        .i_op      (r_op),
        .o_prod    (w_prod),
        .o_quot    (w_quot),
        .o_rem     (w_rem),
        .o_divZero (w_divZero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_stIdle;
            r_count <= 4'd0;
            r_opA   <= 32'd0;
            r_opB   <= 32'd0;
            r_op    <= 3'd0;
            r_busy  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                c_stIdle: begin
                    if (E_start) begin
                        if (isMulDiv(E_mdOp)) begin
                            r_opA   <= E_a;
                            r_opB   <= E_b;
                            r_op    <= E_mdOp;
                            r_count <= isMulOp(E_mdOp) ? c_multCnt : c_divCnt;
                            r_state <= c_stBusy;
                            r_busy  <= 1'b1;
                        end else if (E_mdOp == c_opMthi) begin
                            r_hi <= E_a;
                        end else if (E_mdOp == c_opMtlo) begin
                            r_lo <= E_a;
                        end
                    end
                end
                c_stBusy: begin
                    // E_start here is a protocol violation and is ignored.
                    if (r_count == 4'd1) begin
                        if (isMulOp(r_op)) begin
                            r_hi <= w_prod[63:32];
                            r_lo <= w_prod[31:0];
                        end else if (!w_divZero) begin
                            r_hi <= w_rem;
                            r_lo <= w_quot;
                        end
                        r_count <= 4'd0;
                        r_state <= c_stIdle;
                        r_busy  <= 1'b0;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                default: begin
                    r_state <= c_stIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

    // MTHI/MTLO complete in one cycle, so only multi-cycle starts stall.
    assign D_mdStall = D_isMd & (r_busy | (E_start & isMulDiv(E_mdOp)));

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_ctrl
// Description : Self-checking bench for mdu_ctrl. Stimulus pushes the
//               expected {hi, lo, busy length} into a scoreboard; a monitor
//               pops and compares each time busy falls.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        E_start;
    logic [2:0]  E_mdOp;
    logic [31:0] E_a;
    logic [31:0] E_b;
    logic        D_isMd;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        D_mdStall;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   busyRun = 0;

    mdu_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .E_start   (E_start),
        .E_mdOp    (E_mdOp),
        .E_a       (E_a),
        .E_b       (E_b),
        .D_isMd    (D_isMd),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo),
        .D_mdStall (D_mdStall)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: a completed (or aborted) operation shows as busy falling.
    always @(negedge clk) begin
        exp_t e;
        if (busy === 1'b1) begin
            busyRun++;
        end else if (busyRun != 0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sbUnderflow: got completion with empty scoreboard, expected none");
            end else begin
                e = sb.pop_front();
                checkEq("sbHi", hi, e.hi);
                checkEq("sbLo", lo, e.lo);
                checkEq("sbBusyLen", 32'(busyRun), 32'(e.len));
            end
            busyRun = 0;
        end
    end

    function automatic exp_t mk(input logic [31:0] h, input logic [31:0] l, input int n);
        exp_t e;
        e.hi = h;
        e.lo = l;
        e.len = n;
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 of the first busy cycle.
    task automatic startOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        E_start = 1'b1;
        E_mdOp  = op;
        E_a     = a;
        E_b     = b;
        @(posedge clk); #1;
        E_start = 1'b0;
    endtask

    // Bounded wait for busy low; returns at posedge+1.
    task automatic waitIdle();
        bit done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL waitIdle: got busy stuck high, expected idle within 40 cycles");
        end
        @(posedge clk); #1;
    endtask

    task automatic moveTo(input logic [2:0] op, input logic [31:0] a);
        E_start = 1'b1;
        E_mdOp  = op;
        E_a     = a;
        @(negedge clk);
        checkEq("mtStall", 32'(D_mdStall), 32'd0);
        @(posedge clk); #1;
        E_start = 1'b0;
        checkEq("mtBusy", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        reset   = 1'b1;
        E_start = 1'b0;
        E_mdOp  = c_opMult;
        E_a     = 32'd0;
        E_b     = 32'd0;
        D_isMd  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkEq("rstBusy", 32'(busy), 32'd0);
        checkEq("rstHi", hi, 32'd0);
        checkEq("rstLo", lo, 32'd0);
        checkEq("rstStall", 32'(D_mdStall), 32'd0);
        @(posedge clk); #1;

        // MULT -2 * 3
        sb.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFA, 5));
        startOp(c_opMult, 32'hFFFFFFFE, 32'd3);
        waitIdle();

        // MULTU 0xFFFFFFFF * 2
        sb.push_back(mk(32'h00000001, 32'hFFFFFFFE, 5));
        startOp(c_opMultu, 32'hFFFFFFFF, 32'd2);
        waitIdle();

        // DIV -7 / 2 with D_isMd held high, stall tracked cycle by cycle
        sb.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFD, 10));
        D_isMd  = 1'b1;
        E_start = 1'b1;
        E_mdOp  = c_opDiv;
        E_a     = 32'hFFFFFFF9;
        E_b     = 32'd2;
        @(negedge clk);
        checkEq("divStartStall", 32'(D_mdStall), 32'd1);
        @(posedge clk); #1;
        E_start = 1'b0;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            if (D_mdStall === 1'b1) n++;
        end
        checkEq("divStallCycles", 32'(n), 32'd10);
        checkEq("divStallAfter", 32'(D_mdStall), 32'd0);
        @(posedge clk); #1;

        // MTHI/MTLO preset (D_isMd still high: no stall)
        moveTo(c_opMthi, 32'h11);
        checkEq("mthiHi", hi, 32'h11);
        moveTo(c_opMtlo, 32'h22);
        checkEq("mtloLo", lo, 32'h22);
        checkEq("mtloHiHeld", hi, 32'h11);
        D_isMd = 1'b0;

        // DIVU by zero keeps hi/lo
        sb.push_back(mk(32'h11, 32'h22, 10));
        startOp(c_opDivu, 32'h1234, 32'd0);
        waitIdle();

        // DIV 100 / 7 with an ignored MTLO and operand churn mid-busy
        sb.push_back(mk(32'd2, 32'd14, 10));
        startOp(c_opDiv, 32'd100, 32'd7);
        @(posedge clk); #1;
        @(posedge clk); #1;
        E_start = 1'b1;
        E_mdOp  = c_opMtlo;
        E_a     = 32'h55;
        E_b     = 32'h0;
        @(posedge clk); #1;
        E_start = 1'b0;
        E_a     = 32'hDEAD;
        E_b     = 32'h3;
        waitIdle();

        // DIV overflow case
        sb.push_back(mk(32'd0, 32'h80000000, 10));
        startOp(c_opDiv, 32'h80000000, 32'hFFFFFFFF);
        waitIdle();

        // DIV 7 / -2 -> q=-3, r=1
        sb.push_back(mk(32'd1, 32'hFFFFFFFD, 10));
        startOp(c_opDiv, 32'd7, 32'hFFFFFFFE);
        waitIdle();

        // MULTU max * max
        sb.push_back(mk(32'hFFFFFFFE, 32'h00000001, 5));
        startOp(c_opMultu, 32'hFFFFFFFF, 32'hFFFFFFFF);
        waitIdle();

        // DIVU 0xFFFFFFFF / 0x10
        sb.push_back(mk(32'h0000000F, 32'h0FFFFFFF, 10));
        startOp(c_opDivu, 32'hFFFFFFFF, 32'h10);
        waitIdle();

        // MULT aborted by reset on the 3rd busy cycle
        sb.push_back(mk(32'd0, 32'd0, 3));
        startOp(c_opMult, 32'd1000, 32'd1000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkEq("abortBusy", 32'(busy), 32'd0);
        repeat (8) @(posedge clk);
        #1;
        checkEq("abortHiLater", hi, 32'd0);
        checkEq("abortLoLater", lo, 32'd0);

        // Reset dominates a simultaneous start
        reset   = 1'b1;
        E_start = 1'b1;
        E_mdOp  = c_opMult;
        E_a     = 32'd5;
        E_b     = 32'd5;
        @(posedge clk); #1;
        reset   = 1'b0;
        E_start = 1'b0;
        checkEq("rstDomBusy", 32'(busy), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        checkEq("rstDomLo", lo, 32'd0);

        checkEq("sbEmpty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
